// File: rtl/pipelined_rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder/subtractor:
// geometry checks, segment width and saturation constants.
package pipelined_rca_pkg;

    function automatic bit div_ok(input int w, input int s);
        return (s >= 1) && (s <= w) && ((w % s) == 0);
    endfunction

    function automatic int seg_w(input int w, input int s);
        return w / s;
    endfunction

    function automatic logic [127:0] max_pos(input int w);
        return (128'(1) << (w - 1)) - 128'(1);
    endfunction

    function automatic logic [127:0] max_neg(input int w);
        return 128'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full-adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_segment.sv
// Combinational ripple chain of SEG full-adder cells; also exposes
// the carry into the segment MSB for signed-overflow detection.
module rca_segment
    import pipelined_rca_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] seg_a,
    input  logic [SEG-1:0] seg_b,
    input  logic           seg_cin,
    output logic [SEG-1:0] seg_sum,
    output logic           seg_cout,
    output logic           seg_cmsb
);

    logic [SEG:0] c;

    assign c[0] = seg_cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        fa u_fa (
            .a (seg_a[i]),
            .b (seg_b[i]),
            .ci(c[i]),
            .s (seg_sum[i]),
            .co(c[i+1])
        );
    end

    assign seg_cout = c[SEG];
    assign seg_cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// Define PIPELINED_RCA_SAT_EN to saturate sum on signed overflow.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = seg_w(WIDTH, STAGES);

    if (!div_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_rca: WIDTH must be a multiple of STAGES");
    end

    logic en;

    logic [STAGES-1:0]            v_d, v_q;
    logic [STAGES-1:0]            c_d, c_n, c_q, m_d;
    logic [STAGES-1:0][WIDTH-1:0] a_d, a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_d, b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_d, s_n, s_q;
    logic                         m_q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0] seg_sum;

        if (k == 0) begin : g_first
            assign v_d[0] = in_valid;
            assign a_d[0] = a;
            assign b_d[0] = sub ? ~b : b;
            assign s_d[0] = '0;
            assign c_d[0] = cin ^ sub;
        end else begin : g_next
            assign v_d[k] = v_q[k-1];
            assign a_d[k] = a_q[k-1];
            assign b_d[k] = b_q[k-1];
            assign s_d[k] = s_q[k-1];
            assign c_d[k] = c_q[k-1];
        end

        rca_segment #(.SEG(SEG)) u_seg (
            .seg_a   (a_d[k][k*SEG +: SEG]),
            .seg_b   (b_d[k][k*SEG +: SEG]),
            .seg_cin (c_d[k]),
            .seg_sum (seg_sum),
            .seg_cout(c_n[k]),
            .seg_cmsb(m_d[k])
        );

        // splice this segment's result into the accumulated sum word
        assign s_n[k] = (s_d[k] & ~(WIDTH'({SEG{1'b1}}) << (k * SEG)))
                      | (WIDTH'(seg_sum) << (k * SEG));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
            m_q <= 1'b0;
        end else if (en) begin
            v_q <= v_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_n;
            c_q <= c_n;
            m_q <= m_d[STAGES-1];
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = c_q[STAGES-1] ^ m_q;

`ifdef PIPELINED_RCA_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(max_neg(WIDTH));

    // on overflow the true result has the sign of operand a
    assign sum = !ovf ? s_q[STAGES-1]
               : (a_q[STAGES-1][WIDTH-1] ? MAX_NEG : MAX_POS);
`else
    assign sum = s_q[STAGES-1];
`endif

    logic unused_bits;
    assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], m_d};

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed self-checking bench for pipelined_rca (WIDTH=16, STAGES=4).
module tb_pipelined_rca;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // independent reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [W-1:0] ma,
                                          input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         o;
        logic [W-1:0] s;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, mc ^ ms};
        s    = full[W-1:0];
        o    = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
`ifdef PIPELINED_RCA_SAT_EN
        if (o) s = ma[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {o, full[W], s};
    endfunction

    task automatic run_one(input string tag, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic tc,
                           input logic ts, input logic [W-1:0] es,
                           input logic ec, input logic eo);
        out_ready = 1'b1;
        a         = ta;
        b         = tb;
        cin       = tc;
        sub       = ts;
        in_valid  = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        cyc();
        in_valid = 1'b0;
        for (int i = 1; i < S; i++) begin
            check({tag, "_early"}, out_valid, 0);
            cyc();
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        cyc();
        check({tag, "_drain"}, out_valid, 0);
    endtask

    logic [17:0] expq[$];
    logic [17:0] got;
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];
    logic         vs [8];
    int idx;
    int recv;
    int dup;
    logic pat [4];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);

        run_one("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0,
                16'h0000, 1'b1, 1'b0);
`ifdef PIPELINED_RCA_SAT_EN
        run_one("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
                16'h7FFF, 1'b0, 1'b1);
        run_one("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1,
                16'h8000, 1'b1, 1'b1);
`else
        run_one("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
                16'h8000, 1'b0, 1'b1);
        run_one("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1,
                16'h7FFF, 1'b1, 1'b1);
`endif
        run_one("3_m5", 16'h0003, 16'h0005, 1'b0, 1'b1,
                16'hFFFE, 1'b0, 1'b0);
        run_one("cin_add", 16'h1234, 16'h1111, 1'b1, 1'b0,
                16'h2346, 1'b0, 1'b0);
        run_one("borrow_in", 16'h0005, 16'h0003, 1'b1, 1'b1,
                16'h0001, 1'b1, 1'b0);

        // streaming with back-pressure
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            vc[i] = 1'($urandom_range(1));
            vs[i] = 1'($urandom_range(1));
        end
        idx  = 0;
        recv = 0;
        dup  = 0;
        for (int t = 0; t < 200 && recv < 8; t++) begin
            out_ready = pat[t % 4];
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a   = va[idx];
                b   = vb[idx];
                cin = vc[idx];
                sub = vs[idx];
            end
            #1;
            check("stream_in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    dup++;
                end else begin
                    got = expq.pop_front();
                    check("stream_result", {ovf, cout, sum}, got);
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(va[idx], vb[idx], vc[idx], vs[idx]));
                idx++;
            end
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", recv, 8);
        check("stream_extra", dup, 0);
        cyc();
        check("stream_idle", out_valid, 0);

        // reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            a        = 16'h0100 * W'(i + 1);
            b        = 16'h0001;
            sub      = 1'b0;
            cin      = 1'b0;
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("flush_no_out", out_valid, 0);
            cyc();
        end
        run_one("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0,
                16'h2345, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
